// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the RV32I multicycle controller
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       instr_done;
    } ctl_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op_i);
        case (op_i)
            OP_STORE:  imm_src_of = IMM_S;
            OP_BRANCH: imm_src_of = IMM_B;
            OP_JAL:    imm_src_of = IMM_J;
            default:   imm_src_of = IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op_i);
        case (op_i)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_supported = 1'b1;
            default: op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUop and instruction function fields to alu_control
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only register-register forms can subtract; addi with bit30 set stays add
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing the RV32I multicycle datapath
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t state;
    state_t next_state;
    ctl_t   ctl;
    logic   branch_taken;

    function automatic state_t next_of(input state_t s, input logic [6:0] op_i);
        case (s)
            S_RESET:  next_of = S_FETCH;
            S_FETCH:  next_of = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: next_of = S_MEMADR;
                    OP_RTYPE:          next_of = S_EXECR;
                    OP_ITYPE:          next_of = S_EXECI;
                    OP_BRANCH:         next_of = S_BRANCH;
                    OP_JAL:            next_of = S_JAL;
                    default:           next_of = S_FETCH;
                endcase
            end
            S_MEMADR:  next_of = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_of = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: next_of = S_ALUWB;
            default:   next_of = S_FETCH;
        endcase
    endfunction

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb next_state = next_of(state, op);

    // Controls are registered from the upcoming state so they are glitch-free Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            ctl   <= ctl_of(S_RESET);
        end else begin
            state <= next_state;
            ctl   <= ctl_of(next_state);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    // Only beq/bne can redirect; other branch funct3 values fall through as not taken
    assign branch_taken  = (funct3[2:1] == 2'b00) & (zero ^ funct3[0]);

    assign imm_src       = (state == S_RESET) ? IMM_I : imm_src_of(op);
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign result_src    = ctl.result_src;
    assign adr_src       = ctl.adr_src;
    assign ir_write      = ctl.ir_write;
    assign pc_write      = ctl.pc_update | (ctl.branch & branch_taken);
    assign reg_write     = ctl.reg_write;
    assign mem_write     = ctl.mem_write;
    assign instr_done    = ctl.instr_done;
    assign illegal_instr = (state == S_DECODE) & ~op_supported(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for the multicycle controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write, instr_done, illegal_instr;
    logic [17:0] obs;

    int checks = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .imm_src       (imm_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .result_src    (result_src),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    assign obs = {imm_src, alu_src_a, alu_src_b, alu_control, result_src,
                  adr_src, ir_write, pc_write, reg_write, mem_write, instr_done, illegal_instr};

    function automatic logic [17:0] v(input logic [1:0] imm, input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic [1:0] rs, input logic adr,
                                      input logic irw, input logic pcw, input logic rw, input logic mw,
                                      input logic done, input logic ill);
        return {imm, a, b, alu, rs, adr, irw, pcw, rw, mw, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held three cycles with a store opcode present: selects must still read zero
        op = 7'b0100011;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        op = 7'b0000011;
        reset = 1'b0;
        #1;
        chk("reset_release", v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // lw: 5 cycles
        step(); chk("lw_fetch",   v(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("lw_decode",  v(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("lw_memadr",  v(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("lw_memread", v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        step(); chk("lw_memwb",   v(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0, 1, 0, 1, 0));

        // sw: 4 cycles
        op = 7'b0100011;
        step(); chk("sw_fetch",    v(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("sw_decode",   v(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("sw_memadr",   v(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("sw_memwrite", v(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1, 1, 0));

        // beq: 3 cycles, taken only on zero
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        step(); chk("beq_fetch",  v(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("beq_decode", v(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("beq_taken",  v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 1, 0, 0, 1, 0));
        zero = 1'b0; #1;
        chk("beq_not_taken",      v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0, 1, 0));

        // bne inverts; unsupported branch funct3 never taken
        funct3 = 3'b001; zero = 1'b1;
        step(); chk("bne_fetch",  v(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("bne_decode", v(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("bne_not_taken", v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        zero = 1'b0; #1;
        chk("bne_taken",          v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 1, 0, 0, 1, 0));
        funct3 = 3'b100; #1;
        chk("blt_z0_not_taken",   v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        zero = 1'b1; #1;
        chk("blt_z1_not_taken",   v(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0, 1, 0));

        // R-type: funct decode exercised while parked in S_EXECR
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
        step(); chk("r_fetch",  v(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("r_decode", v(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("r_sub",    v(2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        funct7b5 = 1'b0; #1;
        chk("r_add",            v(2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        funct3 = 3'b111; #1;
        chk("r_and",            v(2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        funct3 = 3'b110; #1;
        chk("r_or",             v(2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        funct3 = 3'b010; #1;
        chk("r_slt",            v(2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        funct3 = 3'b001; #1;
        chk("r_other_add",      v(2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("r_aluwb",  v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 0));

        // I-type: bit30 set must not turn addi into subtract
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        step(); chk("i_fetch",  v(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("i_decode", v(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("i_addi",   v(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("i_aluwb",  v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 0));

        // jal: 4 cycles
        op = 7'b1101111; funct7b5 = 1'b0;
        step(); chk("jal_fetch",  v(2'b11, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("jal_decode", v(2'b11, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("jal_jump",   v(2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        step(); chk("jal_aluwb",  v(2'b11, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 0));

        // illegal opcode: flag in decode, straight back to fetch
        op = 7'b1111111;
        step(); chk("ill_fetch",    v(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        step(); chk("ill_decode",   v(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        step(); chk("ill_refetch",  v(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));

        // reset during S_MEMWRITE drops mem_write without waiting for a clock
        op = 7'b0100011;
        step(); chk("rsw_decode",   v(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("rsw_memadr",   v(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("rsw_memwrite", v(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1, 1, 0));
        #1 reset = 1'b1;
        #1;
        chk("rsw_async_reset",      v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("rsw_reset_held", v(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step(); chk("rsw_restart_fetch", v(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
